ball_motion_seq: RTL

Tick-driven sequencer that advances the labyrinth ball one physics step per frame tick. Each step:
- samples the accelerometer tilt;
- accumulates sub-pixel speed per axis;
- asks the maze map whether each candidate cell is passable, over a req/ack port shared with other map users;
- commits the new ball location.

It sits between the accelerometer controller and the VGA/world-map logic, replacing free-running ball motion with a deterministic, collision-checked update.

---
 rtl/ball_pkg.sv | 26 ++
 rtl/tilt_stepper.sv | 51 +++++
 rtl/ball_motion_seq.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/ball_pkg.sv
// rtl/ball_pkg.sv - shared states, tile codes and constants for the ball motion sequencer
package ball_pkg;

   typedef enum logic [2:0] {
      IDLE,
      SAMPLE,
      CHKX,
      CHKY,
      COMMIT
   } state_t;

   typedef enum logic [1:0] {
      TILE_FLOOR = 2'b00,
      TILE_WALL  = 2'b01,
      TILE_GOAL  = 2'b10,
      TILE_WALL2 = 2'b11
   } tile_t;

   localparam int ACCEL_LEVEL = 256;
   localparam int MAP_AW      = 14;

   function automatic logic tile_blocks(input logic [1:0] t);
      return (t == TILE_WALL) || (t == TILE_WALL2);
   endfunction

endpackage

// File: rtl/tilt_stepper.sv
// rtl/tilt_stepper.sv - per-axis sub-pixel speed accumulator driven by one accelerometer axis
module tilt_stepper
   import ball_pkg::*;
#(
   parameter int DEADZONE = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [8:0] accel,
   input  logic       load,
   input  logic       clear,
   output logic       carry,
   output logic       neg
);
   localparam logic [9:0] LEVEL = 10'(ACCEL_LEVEL);
   localparam logic [9:0] DZ    = 10'(DEADZONE);

   logic [9:0] tilt;
   logic [9:0] abs_tilt;
   logic [9:0] mag_raw;
   logic [7:0] mag;
   logic [8:0] sum;
   logic [7:0] frac_q, frac_d;

   // carry/neg describe the step a load in this cycle produces
   always_comb begin
      tilt     = {1'b0, accel} - LEVEL;
      abs_tilt = tilt[9] ? (~tilt + 10'd1) : tilt;
      mag_raw  = (abs_tilt > DZ) ? (abs_tilt - DZ) : 10'd0;
      mag      = (mag_raw > 10'd255) ? 8'hFF : mag_raw[7:0];
      sum      = {1'b0, frac_q} + {1'b0, mag};
      carry    = sum[8];
      neg      = tilt[9];
      frac_d   = frac_q;
      if (load) begin
         frac_d = sum[7:0];
      end
      if (clear) begin
         frac_d = 8'd0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         frac_q <= 8'd0;
      end else begin
         frac_q <= frac_d;
      end
   end

endmodule

// File: rtl/ball_motion_seq.sv
// rtl/ball_motion_seq.sv - tick divider, step FSM and map handshake for the labyrinth ball
module ball_motion_seq
   import ball_pkg::*;
#(
   parameter int TICK_DIV = 1666666,
   parameter int DEADZONE = 16,
   parameter int MAX_X    = 127,
   parameter int MAX_Y    = 127,
   parameter int START_X  = 8,
   parameter int START_Y  = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              enable,
   input  logic [8:0]        accel_x,
   input  logic [8:0]        accel_y,
   output logic              map_req,
   output logic [MAP_AW-1:0] map_addr,
   input  logic              map_ack,
   input  logic [1:0]        map_data,
   output logic [7:0]        loc_x,
   output logic [7:0]        loc_y,
   output logic              upd,
   output logic              goal,
   output logic              overrun
);
   localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   function automatic logic [8:0] neighbour(input logic [7:0] pos, input logic neg);
      return {1'b0, pos} + (neg ? 9'h1FF : 9'h001);
   endfunction

   function automatic logic on_map(input logic [8:0] c, input int max);
      return !c[8] && (c <= 9'(max));
   endfunction

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [7:0]         loc_x_q, loc_x_d, loc_y_q, loc_y_d;
   logic [7:0]         nx_q, nx_d, ny_q, ny_d;
   logic [6:0]         cy_q, cy_d;
   logic               ychk_q, ychk_d;
   logic               map_req_q, map_req_d;
   logic [MAP_AW-1:0]  map_addr_q, map_addr_d;
   logic               upd_q, upd_d, goal_q, goal_d, overrun_q, overrun_d;
   logic               tick, load, clr_x, clr_y;
   logic               carry_x, neg_x, carry_y, neg_y;
   logic [8:0]         cand_x, cand_y;
   logic [7:0]         x_res;

   tilt_stepper #(.DEADZONE(DEADZONE)) u_step_x (
      .clk(clk), .rst_n(reset), .accel(accel_x), .load(load), .clear(clr_x),
      .carry(carry_x), .neg(neg_x)
   );

   tilt_stepper #(.DEADZONE(DEADZONE)) u_step_y (
      .clk(clk), .rst_n(reset), .accel(accel_y), .load(load), .clear(clr_y),
      .carry(carry_y), .neg(neg_y)
   );

   always_comb begin
      tick       = (cnt_q == CNT_W'(TICK_DIV - 1));
      cnt_d      = tick ? '0 : cnt_q + 1'b1;
      state_d    = state_q;
      loc_x_d    = loc_x_q;
      loc_y_d    = loc_y_q;
      nx_d       = nx_q;
      ny_d       = ny_q;
      cy_d       = cy_q;
      ychk_d     = ychk_q;
      map_req_d  = map_req_q;
      map_addr_d = map_addr_q;
      upd_d      = 1'b0;
      goal_d     = goal_q;
      overrun_d  = tick && (state_q != IDLE);
      load       = 1'b0;
      clr_x      = !enable;
      clr_y      = !enable;
      cand_x     = neighbour(loc_x_q, neg_x);
      cand_y     = neighbour(loc_y_q, neg_y);
      x_res      = nx_q;

      case (state_q)
         IDLE: begin
            if (tick && enable) state_d = SAMPLE;
         end
         // Both axes are resolved here so map_req can be registered for CHKX's first cycle
         SAMPLE: begin
            load   = 1'b1;
            nx_d   = loc_x_q;
            ny_d   = loc_y_q;
            cy_d   = cand_y[6:0];
            ychk_d = 1'b0;
            if (carry_x) begin
               if (on_map(cand_x, MAX_X)) begin
                  map_req_d  = 1'b1;
                  map_addr_d = {loc_y_q[6:0], cand_x[6:0]};
               end else begin
                  clr_x = 1'b1;
               end
            end
            if (carry_y) begin
               if (on_map(cand_y, MAX_Y)) ychk_d = 1'b1;
               else                       clr_y  = 1'b1;
            end
            state_d = CHKX;
         end
         CHKX: begin
            if (map_req_q && map_ack) begin
               if (tile_blocks(map_data)) begin
                  clr_x = 1'b1;
               end else begin
                  x_res = {1'b0, map_addr_q[6:0]};
                  if (map_data == TILE_GOAL) goal_d = 1'b1;
               end
            end
            if (!map_req_q || map_ack) begin
               nx_d      = x_res;
               map_req_d = ychk_q;
               if (ychk_q) map_addr_d = {cy_q, x_res[6:0]};
               state_d   = CHKY;
            end
         end
         CHKY: begin
            if (!map_req_q) begin
               state_d = COMMIT;
            end else if (map_ack) begin
               map_req_d = 1'b0;
               if (tile_blocks(map_data)) begin
                  clr_y = 1'b1;
               end else begin
                  ny_d = {1'b0, map_addr_q[13:7]};
                  if (map_data == TILE_GOAL) goal_d = 1'b1;
               end
               state_d = COMMIT;
            end
         end
         COMMIT: begin
            loc_x_d = nx_q;
            loc_y_d = ny_q;
            upd_d   = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      if (!enable) goal_d = 1'b0;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         loc_x_q    <= 8'(START_X);
         loc_y_q    <= 8'(START_Y);
         nx_q       <= 8'(START_X);
         ny_q       <= 8'(START_Y);
         cy_q       <= 7'd0;
         ychk_q     <= 1'b0;
         map_req_q  <= 1'b0;
         map_addr_q <= '0;
         upd_q      <= 1'b0;
         goal_q     <= 1'b0;
         overrun_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         loc_x_q    <= loc_x_d;
         loc_y_q    <= loc_y_d;
         nx_q       <= nx_d;
         ny_q       <= ny_d;
         cy_q       <= cy_d;
         ychk_q     <= ychk_d;
         map_req_q  <= map_req_d;
         map_addr_q <= map_addr_d;
         upd_q      <= upd_d;
         goal_q     <= goal_d;
         overrun_q  <= overrun_d;
      end
   end

   assign map_req  = map_req_q;
   assign map_addr = map_addr_q;
   assign loc_x    = loc_x_q;
   assign loc_y    = loc_y_q;
   assign upd      = upd_q;
   assign goal     = goal_q;
   assign overrun  = overrun_q;

endmodule
